fifo_burst_reader: RTL

- Read-side master for the async FIFO; runs entirely in the read clock domain.
- On a start pulse it drains a programmed number of words from the FIFO: drives r_en, absorbs the 1-cycle RAM read latency, and presents the words on a valid/ready output stream.
- A 2-entry skid buffer makes output backpressure lossless; status outputs report progress.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/skid_buffer_2.sv | 62 ++++++
 rtl/fifo_burst_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read/write side blocks.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int D_WIDTH    = 8;
  localparam int LEN_WIDTH  = 8;

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry valid/ready buffer; head entry drives the output, FIFO ordering.
module skid_buffer_2
  import fifo_pkg::*;
#(
  parameter int d_width = D_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [d_width-1:0] push_data,
  output logic [d_width-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         occupancy
);

  localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);

  logic [d_width-1:0] head_q;
  logic [d_width-1:0] tail_q;
  logic [1:0]         count_q;
  logic               pop;
  logic               accept_push;

  assign out_data    = head_q;
  assign out_valid   = (count_q != 2'd0);
  assign occupancy   = count_q;
  assign pop         = out_valid && out_ready;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign accept_push = push && ((count_q != DEPTH) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({accept_push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: drains burst_len words from the FIFO onto a valid/ready stream.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int d_width   = D_WIDTH,
  parameter int len_width = LEN_WIDTH
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_width-1:0] burst_len,
  input  logic                 empty,
  output logic                 r_en,
  input  logic [d_width-1:0]   rd_data,
  output logic [d_width-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [len_width-1:0] words_read
);

  state_t               state_q;
  state_t               state_d;
  logic [len_width-1:0] remaining_q;
  logic [len_width-1:0] words_q;
  logic                 inflight_q;
  logic [1:0]           occupancy;
  logic [2:0]           pending;

  assign words_read = words_q;
  // Words already buffered plus the one returning from RAM; keeps the skid from overflowing
  // without looking at m_ready.
  assign pending = {1'b0, occupancy} + {2'b00, inflight_q};

  always_comb begin
    state_d = state_q;
    r_en    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (burst_len == '0) ? DONE : READ;
      end
      READ: begin
        busy = 1'b1;
        r_en = !empty && (remaining_q != '0) && (pending < 3'd2);
        if ((remaining_q == '0) || (r_en && (remaining_q == len_width'(1))))
          state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight_q && (occupancy == 2'd0)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      words_q     <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= r_en;
      if ((state_q == IDLE) && start) begin
        remaining_q <= burst_len;
        words_q     <= '0;
      end else if (r_en) begin
        remaining_q <= remaining_q - len_width'(1);
        words_q     <= words_q + len_width'(1);
      end
    end
  end

  skid_buffer_2 #(
    .d_width(d_width)
  ) u_skid (
    .clk       (rclk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (rd_data),
    .out_data  (m_data),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .occupancy (occupancy)
  );

endmodule
